// File: rtl/mips_pkg.sv
// Purpose: shared MIPS constants (field positions, R-type opcode, NOP word) and the fetch entry type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W  = 32;
  localparam int ENTRY_W = 2 * WORD_W;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JA_MSB  = 25;
  localparam int JA_LSB  = 0;

  localparam logic [5:0]        OPC_RTYPE = 6'h00;
  // sll $0,$0,0 -- what decode sees when nothing is queued
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

  // One queued fetch result: PC in the upper word, instruction in the lower word
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_rtype(input logic [5:0] opc);
    return opc == OPC_RTYPE;
  endfunction

endpackage

// File: rtl/instr_decode_buffer_if.sv
// Purpose: fetch-side and decode-side handshake bundle of the fetch-to-decode buffer, plus flush.
// Latency: n/a (wiring only).
// Backpressure: IN_READY towards fetch, OUT_READY from decode.
interface instr_decode_buffer_if;
  import mips_pkg::*;

  // Fetch side
  logic              IN_VALID;
  logic              IN_READY;
  logic [WORD_W-1:0] IN_PC;
  logic [WORD_W-1:0] IN_INSTR;
  logic              FLUSH;

  // Decode side
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [WORD_W-1:0] OUT_PC;
  logic [WORD_W-1:0] PC_PLUS4;
  logic [WORD_W-1:0] OUT_INSTR;
  logic [5:0]        OPCODE;
  logic [4:0]        RS;
  logic [4:0]        RT;
  logic [4:0]        RD;
  logic [4:0]        SHAMT;
  logic [5:0]        FUNCT;
  logic [15:0]       IMM16;
  logic [25:0]       JADDR;
  logic              IS_RTYPE;

  // Buffer's view
  modport slave (
    input  IN_VALID, IN_PC, IN_INSTR, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_PC, PC_PLUS4, OUT_INSTR,
    output OPCODE, RS, RT, RD, SHAMT, FUNCT, IMM16, JADDR, IS_RTYPE
  );

  // Fetch/decode (environment) view
  modport master (
    output IN_VALID, IN_PC, IN_INSTR, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_PC, PC_PLUS4, OUT_INSTR,
    input  OPCODE, RS, RT, RD, SHAMT, FUNCT, IMM16, JADDR, IS_RTYPE
  );

endinterface

// File: rtl/instr_fifo.sv
// Purpose: generic DEPTH-entry circular queue with valid/ready on both sides, flush and occupancy count.
// Latency: 1 cycle push-to-visible; head is read straight from storage.
// Backpressure: in_rdy = !full from registered count only; no combinational path from out_rdy.
module instr_fifo #(
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_dat,
  output logic [PTR_W:0]    count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push;
  logic              pop;

  assign in_rdy  = count_q < CNT_W'(DEPTH);
  assign out_vld = count_q != '0;
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  // Next pointers/count/storage; flush wins over any push or pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset empties the queue exactly like a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; out_vld gating makes stale contents invisible
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_decode_buffer.sv
// Purpose: fetch-to-decode buffer presenting the queued head split into MIPS fields, plus PC+4.
// Latency: entry pushed at edge N is presented from cycle N+1.
// Backpressure: IN_READY drops only when the queue is full; head and fields hold while OUT_READY=0.
module instr_decode_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  instr_decode_buffer_if.slave  bus
);

  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t      in_entry;
  fetch_entry_t      head_entry;
  logic              head_vld;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] head_pc;
  logic [WORD_W-1:0] head_instr;

  assign in_entry = '{pc: bus.IN_PC, instr: bus.IN_INSTR};

  instr_fifo #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .flush   (bus.FLUSH),
    .in_vld  (bus.IN_VALID),
    .in_rdy  (bus.IN_READY),
    .in_dat  (in_entry),
    .out_vld (head_vld),
    .out_rdy (bus.OUT_READY),
    .out_dat (head_entry),
    .count   (fifo_count)
  );

  // Empty queue reads as a NOP at PC 0 so stale storage never leaks out
  assign head_pc    = head_vld ? head_entry.pc    : '0;
  assign head_instr = head_vld ? head_entry.instr : INSTR_NOP;

  assign bus.OUT_VALID = head_vld;
  assign bus.OUT_PC    = head_pc;
  assign bus.OUT_INSTR = head_instr;
  assign bus.PC_PLUS4  = head_pc + 32'd4;
  assign bus.OPCODE    = head_instr[OPC_MSB:OPC_LSB];
  assign bus.RS        = head_instr[RS_MSB:RS_LSB];
  assign bus.RT        = head_instr[RT_MSB:RT_LSB];
  assign bus.RD        = head_instr[RD_MSB:RD_LSB];
  assign bus.SHAMT     = head_instr[SH_MSB:SH_LSB];
  assign bus.FUNCT     = head_instr[FN_MSB:FN_LSB];
  assign bus.IMM16     = head_instr[IMM_MSB:IMM_LSB];
  assign bus.JADDR     = head_instr[JA_MSB:JA_LSB];
  assign bus.IS_RTYPE  = head_vld && is_rtype(head_instr[OPC_MSB:OPC_LSB]);

  // Occupancy can never exceed the queue size
  a_count_bound : assert property (@(posedge CLK) disable iff (RST)
    fifo_count <= CNT_W'(DEPTH));

  // Fetch must not change a stalled instruction unless it withdraws it or a redirect happens
  a_in_hold : assert property (@(posedge CLK) disable iff (RST)
    (bus.IN_VALID && !bus.IN_READY && !bus.FLUSH) |=>
      (!bus.IN_VALID || ($stable(bus.IN_PC) && $stable(bus.IN_INSTR))));

endmodule

// File: tb/tb_instr_decode_buffer.sv
module tb_instr_decode_buffer;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic CLK = 1'b0;
  logic RST;

  instr_decode_buffer_if bus();

  instr_decode_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of {pc, instr}
  logic [63:0] mq[$];

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        ordy;
    logic        e_ovld;
    logic        e_irdy;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t tbl[7];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [31:0] pc,
                       input logic [31:0] ins, input logic fl, input logic ordy);
    RST           = rst;
    bus.IN_VALID  = vld;
    bus.IN_PC     = pc;
    bus.IN_INSTR  = ins;
    bus.FLUSH     = fl;
    bus.OUT_READY = ordy;
  endtask

  // Advance model with the inputs applied this cycle, then let the DUT take the edge
  task automatic tick();
    bit full;
    bit has;
    full = mq.size() >= DEPTH;
    has  = mq.size() != 0;
    if (RST || bus.FLUSH) begin
      mq.delete();
    end else begin
      if (has && bus.OUT_READY) void'(mq.pop_front());
      if (bus.IN_VALID && !full) mq.push_back({bus.IN_PC, bus.IN_INSTR});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic        v;
    logic [31:0] epc;
    logic [31:0] ein;
    v   = mq.size() != 0;
    epc = v ? mq[0][63:32] : 32'h0;
    ein = v ? mq[0][31:0]  : 32'h0;
    cmp($sformatf("%s.out_valid", tag), 32'(bus.OUT_VALID), 32'(v));
    cmp($sformatf("%s.in_ready", tag),  32'(bus.IN_READY),  32'(mq.size() < DEPTH));
    cmp($sformatf("%s.out_pc", tag),    bus.OUT_PC,    epc);
    cmp($sformatf("%s.out_instr", tag), bus.OUT_INSTR, ein);
    cmp($sformatf("%s.pc_plus4", tag),  bus.PC_PLUS4,  epc + 32'd4);
    cmp($sformatf("%s.opcode", tag),    32'(bus.OPCODE), 32'(ein[31:26]));
    cmp($sformatf("%s.rs", tag),        32'(bus.RS),     32'(ein[25:21]));
    cmp($sformatf("%s.rt", tag),        32'(bus.RT),     32'(ein[20:16]));
    cmp($sformatf("%s.rd", tag),        32'(bus.RD),     32'(ein[15:11]));
    cmp($sformatf("%s.shamt", tag),     32'(bus.SHAMT),  32'(ein[10:6]));
    cmp($sformatf("%s.funct", tag),     32'(bus.FUNCT),  32'(ein[5:0]));
    cmp($sformatf("%s.imm16", tag),     32'(bus.IMM16),  32'(ein[15:0]));
    cmp($sformatf("%s.jaddr", tag),     32'(bus.JADDR),  32'(ein[25:0]));
    cmp($sformatf("%s.is_rtype", tag),  32'(bus.IS_RTYPE), 32'(v && ein[31:26] == 6'h00));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] slist[4];
    logic        rv, rfl, rrst, rordy, hold;
    logic [31:0] rpc, rins;

    slist[0] = 32'h0109_5020;  // add $10,$8,$9
    slist[1] = 32'h2108_FFFC;  // addi $8,$8,-4
    slist[2] = 32'h8D09_0004;  // lw $9,4($8)
    slist[3] = 32'h0C10_0010;  // jal

    //                vld   pc            ins           fl    ordy  ovld  irdy  e_pc          e_ins
    tbl[0] = '{1'b1, 32'h0040_0000, 32'h2108_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h2108_FFFC};
    tbl[1] = '{1'b1, 32'h0040_0004, 32'h0109_5020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 32'h2108_FFFC};
    tbl[2] = '{1'b1, 32'h0040_0008, 32'h8D09_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 32'h2108_FFFC};
    tbl[3] = '{1'b1, 32'h0040_0008, 32'h8D09_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0004, 32'h0109_5020};
    tbl[4] = '{1'b1, 32'h0040_0008, 32'h8D09_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0008, 32'h8D09_0004};
    tbl[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};

    // Reset for two cycles
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cmp("reset.out_valid", 32'(bus.OUT_VALID), 32'h0);
    cmp("reset.in_ready",  32'(bus.IN_READY),  32'h1);
    cmp("reset.out_instr", bus.OUT_INSTR, 32'h0);
    cmp("reset.pc_plus4",  bus.PC_PLUS4,  32'h4);
    check_model("reset");

    // Single push of addi
    drive(1'b0, 1'b1, 32'h0040_0000, 32'h2108_FFFC, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cmp("single.out_valid", 32'(bus.OUT_VALID), 32'h1);
    cmp("single.opcode",    32'(bus.OPCODE),    32'h08);
    cmp("single.rs",        32'(bus.RS),        32'd8);
    cmp("single.rt",        32'(bus.RT),        32'd8);
    cmp("single.imm16",     32'(bus.IMM16),     32'hFFFC);
    cmp("single.pc_plus4",  bus.PC_PLUS4,       32'h0040_0004);
    cmp("single.is_rtype",  32'(bus.IS_RTYPE),  32'h0);
    // Held head stays stable while decode stalls
    tick();
    cmp("held.out_pc",    bus.OUT_PC,    32'h0040_0000);
    cmp("held.out_instr", bus.OUT_INSTR, 32'h2108_FFFC);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_model("single.drain");

    // Fill, blocked push, drain in order
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, tbl[i].vld, tbl[i].pc, tbl[i].ins, tbl[i].fl, tbl[i].ordy);
      tick();
      cmp($sformatf("tbl%0d.out_valid", i), 32'(bus.OUT_VALID), 32'(tbl[i].e_ovld));
      cmp($sformatf("tbl%0d.in_ready", i),  32'(bus.IN_READY),  32'(tbl[i].e_irdy));
      cmp($sformatf("tbl%0d.out_pc", i),    bus.OUT_PC,    tbl[i].e_pc);
      cmp($sformatf("tbl%0d.out_instr", i), bus.OUT_INSTR, tbl[i].e_ins);
      check_model($sformatf("tbl%0d", i));
    end

    // Streaming: one in, one out every cycle
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 32'h0000_1000 + 32'(4 * k), slist[k % 4], 1'b0, 1'b1);
      tick();
      cmp($sformatf("stream%0d.out_pc", k), bus.OUT_PC, 32'h0000_1000 + 32'(4 * k));
      cmp($sformatf("stream%0d.in_ready", k), 32'(bus.IN_READY), 32'h1);
      check_model($sformatf("stream%0d", k));
      if (k == 0) begin
        cmp("stream.rd",       32'(bus.RD),       32'd10);
        cmp("stream.funct",    32'(bus.FUNCT),    32'h20);
        cmp("stream.is_rtype", 32'(bus.IS_RTYPE), 32'h1);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_model("stream.drain");

    // Flush with two queued entries and a push in the same cycle
    drive(1'b0, 1'b1, 32'h0000_2000, 32'h2108_0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_2004, 32'h2108_0002, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0000_2008, 32'h2108_0003, 1'b1, 1'b1);
    tick();
    cmp("flush.out_valid", 32'(bus.OUT_VALID), 32'h0);
    cmp("flush.in_ready",  32'(bus.IN_READY),  32'h1);
    cmp("flush.pc_plus4",  bus.PC_PLUS4,       32'h4);
    drive(1'b0, 1'b1, 32'h0000_3000, 32'h0109_5020, 1'b0, 1'b0);
    tick();
    cmp("flush.next_pc",    bus.OUT_PC,    32'h0000_3000);
    cmp("flush.next_instr", bus.OUT_INSTR, 32'h0109_5020);
    check_model("flush.next");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();

    // Pointer wrap, then reset while full
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(1'b0, 1'b1, 32'h0000_4000 + 32'(4 * k), slist[(k + 1) % 4], 1'b0, 1'b1);
      tick();
      check_model($sformatf("wrap%0d", k));
    end
    for (int k = 0; k < DEPTH && mq.size() < DEPTH; k++) begin
      drive(1'b0, 1'b1, 32'h0000_5000 + 32'(4 * k), slist[k % 4], 1'b0, 1'b0);
      tick();
    end
    cmp("wrap.full_in_ready", 32'(bus.IN_READY), 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cmp("rst_full.out_valid", 32'(bus.OUT_VALID), 32'h0);
    cmp("rst_full.in_ready",  32'(bus.IN_READY),  32'h1);
    cmp("rst_full.out_instr", bus.OUT_INSTR,      32'h0);
    check_model("rst_full");

    // Randomized traffic against the queue model
    hold = 1'b0;
    rv   = 1'b0;
    rpc  = 32'h0;
    rins = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      rrst  = $urandom_range(0, 99) == 0;
      rfl   = $urandom_range(0, 19) == 0;
      rordy = $urandom_range(0, 9) < 6;
      if (!hold) begin
        rv   = $urandom_range(0, 9) < 7;
        rpc  = $urandom & 32'hFFFF_FFFC;
        rins = $urandom;
        if ($urandom_range(0, 3) == 0) rins[31:26] = 6'h00;
      end
      drive(rrst, rv, rpc, rins, rfl, rordy);
      hold = rv && (mq.size() >= DEPTH) && !rfl && !rrst;
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
